// File: rtl/riscv_uart_tx_pkg.sv
// Shared definitions for the console UART transmitter: FSM encodings, io addresses
// and the bit layout of the status word returned on load reads.
package riscv_uart_tx_pkg;

  localparam logic [1:0] UART_TX_STATE_IDLE  = 2'd0;
  localparam logic [1:0] UART_TX_STATE_START = 2'd1;
  localparam logic [1:0] UART_TX_STATE_DATA  = 2'd2;
  localparam logic [1:0] UART_TX_STATE_STOP  = 2'd3;

  localparam logic [31:0] UART_TX_DATA_ADDR = 32'h9000_0000;
  localparam logic [31:0] UART_TX_STAT_ADDR = 32'h9000_0004;

  // Status word {overflow, tx_busy, fifo_full, fifo_empty, count} for the default 16-deep FIFO
  localparam int UART_TX_STAT_COUNT_LSB = 0;
  localparam int UART_TX_STAT_COUNT_W   = 5;
  localparam int UART_TX_STAT_EMPTY_BIT = 5;
  localparam int UART_TX_STAT_FULL_BIT  = 6;
  localparam int UART_TX_STAT_BUSY_BIT  = 7;
  localparam int UART_TX_STAT_OVF_BIT   = 8;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with show-ahead read data; pushes while full and pops while empty
// are ignored, so callers may treat the flags as advisory.
module riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  // A pop in the same cycle never makes room for a push into a full FIFO
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/riscv_uart_tx.sv
// Memory-mapped console UART transmitter: buffers stored bytes and sends them 8N1,
// LSB first, with back-to-back frames leaving no idle gap.
module riscv_uart_tx
  import riscv_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_count,
  output logic          tx_busy,
  output logic          overflow,
  output logic          tx_done,
  output logic          tx
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic          pop;
  logic          baud_last;
  logic [7:0]    fifo_rdata;

  riscv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign baud_last = (baud_q == BAUD_LAST);
  assign tx_busy   = (state_q != UART_TX_STATE_IDLE);
  assign tx_done   = (state_q == UART_TX_STATE_STOP) && baud_last;
  assign overflow  = ovf_q;
  assign tx        = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      UART_TX_STATE_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = UART_TX_STATE_START;
        end
      end
      UART_TX_STATE_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = UART_TX_STATE_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UART_TX_STATE_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = UART_TX_STATE_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        // Chaining straight into the next start bit keeps queued frames gapless
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            tx_d    = 1'b0;
            state_d = UART_TX_STATE_START;
          end else begin
            state_d = UART_TX_STATE_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && fifo_full) ovf_d = 1'b1;
    else if (clr_ovf)       ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= UART_TX_STATE_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule
